// File: rtl/mult_div_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negate; the most negative value maps to itself.
module md_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);
    always_comb begin
        o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(ITERS + 1);

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH:0]   r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH:0]     w_upper;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_prod_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic               w_b_zero;

    md_negate #(.WIDTH(WIDTH)) u_abs_a (.i_neg(bus.a[WIDTH-1]), .i_val(bus.a), .o_val(w_abs_a));
    md_negate #(.WIDTH(WIDTH)) u_abs_b (.i_neg(bus.b[WIDTH-1]), .i_val(bus.b), .o_val(w_abs_b));
    md_negate #(.WIDTH(WIDTH)) u_quo   (.i_neg(r_sa ^ r_sb),    .i_val(r_quo), .o_val(w_quo_s));
    md_negate #(.WIDTH(WIDTH)) u_rem   (.i_neg(r_sa),           .i_val(r_rem), .o_val(w_rem_s));

    assign w_b_zero = (bus.b == '0);

    // Booth step: the accumulator is widened by one bit so that subtracting the
    // most negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        w_upper = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
        w_sum   = w_upper;
        case (r_prod[1:0])
            2'b01:   w_sum = w_upper + {r_opnd[WIDTH-1], r_opnd};
            2'b10:   w_sum = w_upper - {r_opnd[WIDTH-1], r_opnd};
            default: w_sum = w_upper;
        endcase
        w_prod_next = {w_sum, r_prod[WIDTH:1]};
    end

    // Restoring step on magnitudes; the remainder always ends below the divisor,
    // so a WIDTH-bit modular difference is exact whenever the trial succeeds.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        w_diff  = w_shift[WIDTH-1:0] - r_opnd;
    end

    always_comb begin
        w_next     = r_state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = (bus.op == OP_DIV && w_b_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (r_cnt == CW'(ITERS - 1)) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                bus.busy = 1'b1;
                w_next   = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= OP_MULT;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_opnd     <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt      <= '0;
                        r_op       <= bus.op;
                        r_sa       <= bus.a[WIDTH-1];
                        r_sb       <= bus.b[WIDTH-1];
                        r_div_zero <= (bus.op == OP_DIV) && w_b_zero;
                        if (bus.op == OP_MULT) begin
                            r_opnd <= bus.a;
                            r_prod <= {{WIDTH{1'b0}}, bus.b, 1'b0};
                        end else begin
                            r_opnd <= w_abs_b;
                            r_quo  <= w_abs_a;
                            r_rem  <= '0;
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == OP_MULT) begin
                        r_prod <= w_prod_next;
                    end else begin
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end
                end
                FIX: begin
                    if (r_op == OP_MULT) begin
                        r_hi <= r_prod[2*WIDTH:WIDTH+1];
                        r_lo <= r_prod[WIDTH:1];
                    end else begin
                        r_hi <= w_rem_s;
                        r_lo <= w_quo_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized checks of mult_div_unit against an arithmetic reference.
module tb_mult_div_unit;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse; the operands and op
    // are scrambled after acceptance and a stray start is pulsed while busy.
    task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input bit hold_start);
        longint    sa;
        longint    sb;
        longint    p;
        longint    q;
        longint    r;
        logic [63:0] pv;
        logic [31:0] n_hi;
        logic [31:0] n_lo;
        bit        dz;
        int        exp_lat;
        int        n;
        bit        seen;

        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        dz = (op_i == 1'b1) && (b_i == 32'd0);
        if (op_i == 1'b0) begin
            p    = sa * sb;
            pv   = p;
            n_hi = pv[63:32];
            n_lo = pv[31:0];
        end else if (dz) begin
            n_hi = exp_hi;
            n_lo = exp_lo;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            n_lo = q[31:0];
            n_hi = r[31:0];
        end
        exp_lat = dz ? 1 : 34;

        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clock); #1;
            n++;
            if (n == 1) begin
                bus.a  = $urandom;
                bus.b  = $urandom;
                bus.op = ~op_i;
                if (!hold_start) bus.start = 1'b0;
            end
            if (n == 5) bus.start = 1'b1;
            if (n == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else if (n == 10) begin
                check("hold_lo_mid_run", {32'd0, bus.lo}, {32'd0, exp_lo});
                check("busy_mid_run", {63'd0, bus.busy}, 64'd1);
            end
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("hi", {32'd0, bus.hi}, {32'd0, n_hi});
        check("lo", {32'd0, bus.lo}, {32'd0, n_lo});
        check("div_zero", {63'd0, bus.div_zero}, {63'd0, dz});
        check("busy_at_done", {63'd0, bus.busy}, 64'd1);
        exp_hi = n_hi;
        exp_lo = n_lo;
        exp_dz = dz;

        @(posedge clock); #1;
        bus.start = 1'b0;
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);
        check("idle_after_done", {63'd0, bus.busy}, 64'd0);
        check("hi_held", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(posedge clock); #1;
        check("no_extra_done", {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] corners [5];
        int          done_cnt;

        checks    = 0;
        failures  = 0;
        exp_hi    = '0;
        exp_lo    = '0;
        exp_dz    = 1'b0;
        corners[0] = 32'h8000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'h0000_0001;
        corners[4] = 32'h7FFF_FFFF;

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {bus.hi, bus.lo}, 64'd0);
        check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mult_7_m3", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 32'd100, 32'd7, 1'b0);
        do_op(1'b1, 32'h0246_9234, 32'h0000_2000, 1'b0);
        check("prior_0x1234", {exp_hi, exp_lo}, 64'h0000_1234_0000_1234);
        do_op(1'b1, 32'd5, 32'd0, 1'b1);

        // Reset in the middle of a multiply.
        bus.op    = 1'b0;
        bus.a     = 32'd12345;
        bus.b     = 32'd678;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_mid_flags", {62'd0, bus.done, bus.div_zero}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        do_op(1'b0, 32'd12345, 32'd678, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 5) == 0) rb = $urandom_range(1, 9);
            do_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
